// File: rtl/des_iterative_core.sv
// des_iterative_core
//   Iterative DES engine: one Feistel round per clock, 16 rounds per block,
//   encrypt or decrypt selected per block.
//
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   data_in/key/decrypt carry a block to start
//   in_ready   core is idle and will take a block on this edge
//   data_in    64-bit input block, bit 64 = DES bit 1
//   key        64-bit key incl. parity (parity bits ignored)
//   decrypt    0 = encrypt, 1 = decrypt, latched with the block
//   out_valid  data_out holds a finished result
//   out_ready  consumer takes data_out on this edge
//   data_out   64-bit result block, same ordering as data_in
module des_iterative_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] data_in,
    input  logic [64:1] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] data_out
);

    // Permutation tables hold 1-based DES bit numbers (bit 1 = MSB).
    localparam int IP_TBL [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                   62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                   57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_TBL [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                   38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                   36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                   34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_TBL [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                  16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_TBL [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                  2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_TBL [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_TBL [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // S-boxes, row-major: entry index = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_TBL[k])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_TBL[k])];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[5'(32 - E_TBL[k])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int k = 0; k < 32; k++) y[5'(31 - k)] = x[5'(32 - P_TBL[k])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_TBL[k])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_TBL[k])];
        return y;
    endfunction

    // Rotate a 28-bit key half by 0, 1 or 2 places; "left" moves DES bit 2 into bit 1.
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic dir_left,
                                          input logic [1:0] amt);
        logic [27:0] y;
        case ({dir_left, amt})
            3'b101:  y = {x[26:0], x[27]};
            3'b110:  y = {x[25:0], x[27:26]};
            3'b001:  y = {x[0], x[27:1]};
            3'b010:  y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    // Key-schedule shift for schedule step n (1..16).
    function automatic logic [1:0] sched(input logic [4:0] n);
        return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    state_t      state_reg, state_next;
    logic [4:0]  round_reg;
    logic [31:0] l_reg, r_reg;
    logic [55:0] cd_reg, cd_start_reg;
    logic        decrypt_reg;
    logic [63:0] data_out_reg;

    logic [1:0]  rot_amt;
    logic [27:0] c_rot, d_rot;
    logic [55:0] cd_next;
    logic [47:0] round_key, sbox_in;
    logic [31:0] sbox_out, r_new;

    // Decrypt walks the schedule backwards: round 1 uses the unrotated key,
    // later rounds undo the encrypt shift of step 18-i.
    always_comb begin
        rot_amt = sched(round_reg);
        if (decrypt_reg) begin
            rot_amt = (round_reg == 5'd1) ? 2'd0 : sched(5'd18 - round_reg);
        end
    end

    assign c_rot     = rot28(cd_reg[55:28], !decrypt_reg, rot_amt);
    assign d_rot     = rot28(cd_reg[27:0],  !decrypt_reg, rot_amt);
    assign round_key = perm_pc2({c_rot, d_rot});
    assign sbox_in   = perm_e(r_reg) ^ round_key;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sbox
            logic [5:0] six;
            assign six = sbox_in[47 - 6*gi -: 6];
            // Outer bits pick the row, inner four bits pick the column.
            assign sbox_out[31 - 4*gi -: 4] = 4'(SBOX[gi][{six[5], six[0], six[4:1]}]);
        end
    endgenerate

    assign r_new = l_reg ^ perm_p(sbox_out);

    // Decrypt rotates 27 places over its 16 rounds; one extra right step on
    // the last round returns C/D to C0/D0, matching encrypt's full 28.
    assign cd_next = (decrypt_reg && round_reg == 5'd16)
                   ? {rot28(c_rot, 1'b0, 2'd1), rot28(d_rot, 1'b0, 2'd1)}
                   : {c_rot, d_rot};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (round_reg == 5'd16) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_reg    <= '0;
            l_reg        <= '0;
            r_reg        <= '0;
            cd_reg       <= '0;
            cd_start_reg <= '0;
            decrypt_reg  <= 1'b0;
            data_out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    {l_reg, r_reg} <= perm_ip(data_in);
                    cd_reg         <= perm_pc1(key);
                    cd_start_reg   <= perm_pc1(key);
                    decrypt_reg    <= decrypt;
                    round_reg      <= 5'd1;
                end
                RUN: begin
                    l_reg     <= r_reg;
                    r_reg     <= r_new;
                    cd_reg    <= cd_next;
                    round_reg <= round_reg + 5'd1;
                    // Output takes the halves swapped: {R16, L16}.
                    if (round_reg == 5'd16) data_out_reg <= perm_fp({r_new, r_reg});
                end
                default: ;
            endcase
        end
    end

    // The key schedule must close on itself after every block.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == DONE) begin
            assert (cd_reg == cd_start_reg);
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE) && !rst;
    assign data_out  = data_out_reg;

endmodule
